alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_if.sv | 63 ++++++
 rtl/alu_sequencer.sv | 150 +++++++++++++++
 tb/tb_alu_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Request/response and ALU-side bus of the ALU sequencer, plus the shared ALU op codes.
// The sequencer sits on the slave modport; the requester/consumer/ALU environment uses master.
`ifndef ALU_ADD
`define ALU_ADD 3'd0
`endif
`ifndef ALU_SUB
`define ALU_SUB 3'd1
`endif
`ifndef ALU_AND
`define ALU_AND 3'd2
`endif
`ifndef ALU_OR
`define ALU_OR 3'd3
`endif
`ifndef ALU_XOR
`define ALU_XOR 3'd4
`endif

interface alu_sequencer_if #(parameter int N = 8);
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_mode;
  logic [N-1:0] req_a;
  logic [N-1:0] req_b;

  logic         alu_enable;
  logic [2:0]   alu_mode;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [N-1:0] alu_out;
  logic         alu_flag_zero;
  logic         alu_flag_carry;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_result;
  logic         rsp_zero;
  logic         rsp_carry;
  logic         rsp_err;

  logic         flag_z;
  logic         flag_c;

  modport slave (
    input  req_valid, req_mode, req_a, req_b,
    input  alu_out, alu_flag_zero, alu_flag_carry,
    input  rsp_ready,
    output req_ready,
    output alu_enable, alu_mode, alu_a, alu_b,
    output rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_err,
    output flag_z, flag_c
  );

  modport master (
    output req_valid, req_mode, req_a, req_b,
    output alu_out, alu_flag_zero, alu_flag_carry,
    output rsp_ready,
    input  req_ready,
    input  alu_enable, alu_mode, alu_a, alu_b,
    input  rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_err,
    input  flag_z, flag_c
  );
endinterface

// File: rtl/alu_sequencer.sv
// Issues one request at a time to a registered ALU and returns its result with per-op flags,
// maintaining the architectural Z/C flags used by branch logic.
//
// state | meaning
// IDLE  | ready for a request; operands latched on accept
// ISSUE | alu_enable pulsed for one cycle
// WAIT  | two-cycle settle, ALU result captured on terminal count
// RESP  | response held until the consumer takes it
module alu_sequencer #(
  parameter int N = 8
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  alu_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_next;

  logic         r_wait_cnt;
  logic [2:0]   r_alu_mode;
  logic [N-1:0] r_alu_a;
  logic [N-1:0] r_alu_b;
  logic [N-1:0] r_rsp_result;
  logic         r_rsp_zero;
  logic         r_rsp_carry;
  logic         r_rsp_err;
  logic         r_flag_z;
  logic         r_flag_c;

  logic         w_accept;
  logic         w_capture;
  logic         w_done;
  logic         w_mode_legal;
  logic         w_mode_arith;
  logic         w_req_ready;
  logic         w_alu_enable;
  logic         w_rsp_valid;

  assign w_accept  = (r_state == S_IDLE) && bus.req_valid;
  assign w_capture = (r_state == S_WAIT) && (r_wait_cnt == 1'b0);
  assign w_done    = (r_state == S_RESP) && bus.rsp_ready;

  assign w_mode_arith = (r_alu_mode == `ALU_ADD) || (r_alu_mode == `ALU_SUB);
  assign w_mode_legal = w_mode_arith || (r_alu_mode == `ALU_AND) ||
                        (r_alu_mode == `ALU_OR) || (r_alu_mode == `ALU_XOR);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.req_valid) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_capture) w_next = S_RESP;
      S_RESP:  if (bus.rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_req_ready  = 1'b0;
    w_alu_enable = 1'b0;
    w_rsp_valid  = 1'b0;
    unique case (r_state)
      S_IDLE:  w_req_ready  = 1'b1;
      S_ISSUE: w_alu_enable = 1'b1;
      S_WAIT:  ;
      S_RESP:  w_rsp_valid  = 1'b1;
      default: ;
    endcase
  end

  // Operands held from accept until the next accept; response and flags change only at capture.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wait_cnt   <= 1'b0;
      r_alu_mode   <= 3'd0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_carry  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_flag_z     <= 1'b0;
      r_flag_c     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_alu_mode <= bus.req_mode;
        r_alu_a    <= bus.req_a;
        r_alu_b    <= bus.req_b;
      end

      if (r_state == S_ISSUE) begin
        r_wait_cnt <= 1'b1;
      end else if ((r_state == S_WAIT) && (r_wait_cnt != 1'b0)) begin
        r_wait_cnt <= r_wait_cnt - 1'b1;
      end

      if (w_capture) begin
        if (w_mode_legal) begin
          r_rsp_result <= bus.alu_out;
          r_rsp_zero   <= bus.alu_flag_zero;
          r_rsp_carry  <= w_mode_arith & bus.alu_flag_carry;
          r_rsp_err    <= 1'b0;
          r_flag_z     <= bus.alu_flag_zero;
          if (w_mode_arith) begin
            r_flag_c <= bus.alu_flag_carry;
          end
        end else begin
          // Illegal op: mirror the ALU default (zero result) and leave architectural flags alone.
          r_rsp_result <= '0;
          r_rsp_zero   <= 1'b1;
          r_rsp_carry  <= 1'b0;
          r_rsp_err    <= 1'b1;
        end
      end
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.alu_enable = w_alu_enable;
  assign bus.alu_mode   = r_alu_mode;
  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.rsp_valid  = w_rsp_valid;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_zero   = r_rsp_zero;
  assign bus.rsp_carry  = r_rsp_carry;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.flag_z     = r_flag_z;
  assign bus.flag_c     = r_flag_c;

  logic w_unused;
  assign w_unused = w_done;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural registered ALU and hand-computed results.
module tb_alu_sequencer;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_BAD = 3'd7;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   n_en;

  alu_sequencer_if #(.N(8)) bus ();

  alu_sequencer #(.N(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: result registered on the edge that samples alu_enable.
  always @(posedge clk) begin
    logic [8:0] t;
    if (!rst_n) begin
      bus.alu_out        <= 8'h00;
      bus.alu_flag_zero  <= 1'b0;
      bus.alu_flag_carry <= 1'b0;
    end else if (bus.alu_enable) begin
      case (bus.alu_mode)
        OP_ADD:  t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        OP_SUB:  t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
        OP_AND:  t = {1'b0, bus.alu_a & bus.alu_b};
        OP_OR:   t = {1'b0, bus.alu_a | bus.alu_b};
        OP_XOR:  t = {1'b0, bus.alu_a ^ bus.alu_b};
        default: t = 9'h000;
      endcase
      bus.alu_out        <= t[7:0];
      bus.alu_flag_zero  <= (t[7:0] == 8'h00);
      bus.alu_flag_carry <= t[8];
    end
  end

  always @(negedge clk) if (bus.alu_enable) n_en = n_en + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept at edge k, then observe the k+1..k+3 latency profile; leaves time at k+3 + 1.
  task automatic run_op(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b);
    int en0;
    en0 = n_en;
    bus.req_valid = 1'b1;
    bus.req_mode  = m;
    bus.req_a     = a;
    bus.req_b     = b;
    tick();
    bus.req_valid = 1'b0;
    chk("accept_enable", bus.alu_enable, 1);
    chk("accept_ready", bus.req_ready, 0);
    chk("accept_a", bus.alu_a, a);
    chk("accept_b", bus.alu_b, b);
    tick();
    chk("k1_enable", bus.alu_enable, 0);
    chk("k1_valid", bus.rsp_valid, 0);
    tick();
    chk("k2_valid", bus.rsp_valid, 0);
    tick();
    chk("k3_valid", bus.rsp_valid, 1);
    chk("enable_pulses", n_en - en0, 1);
  endtask

  task automatic check_rsp(input string tag, input logic [7:0] res, input logic z, input logic c,
                           input logic e, input logic fz, input logic fc);
    chk({tag, "_result"}, bus.rsp_result, res);
    chk({tag, "_zero"}, bus.rsp_zero, z);
    chk({tag, "_carry"}, bus.rsp_carry, c);
    chk({tag, "_err"}, bus.rsp_err, e);
    chk({tag, "_flag_z"}, bus.flag_z, fz);
    chk({tag, "_flag_c"}, bus.flag_c, fc);
    tick();
    chk({tag, "_idle"}, bus.req_ready, 1);
    chk({tag, "_valid_drop"}, bus.rsp_valid, 0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_en     = 0;
    rst_n    = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_mode  = 3'd0;
    bus.req_a     = 8'h00;
    bus.req_b     = 8'h00;
    bus.rsp_ready = 1'b1;

    tick();
    tick();
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_alu_enable", bus.alu_enable, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_rsp_zero", bus.rsp_zero, 0);
    chk("rst_rsp_carry", bus.rsp_carry, 0);
    chk("rst_flags", {bus.flag_z, bus.flag_c}, 0);
    chk("rst_alu_regs", {bus.alu_mode, bus.alu_a, bus.alu_b}, 0);
    chk("rst_rsp_result", bus.rsp_result, 0);
    rst_n = 1'b1;

    run_op(OP_ADD, 8'h0F, 8'h01);
    check_rsp("add_0f_01", 8'h10, 0, 0, 0, 0, 0);
    run_op(OP_ADD, 8'hFF, 8'h01);
    check_rsp("add_ff_01", 8'h00, 1, 1, 0, 1, 1);
    run_op(OP_AND, 8'hF0, 8'h0F);
    check_rsp("and_f0_0f", 8'h00, 1, 0, 0, 1, 1);
    run_op(OP_SUB, 8'h03, 8'h05);
    check_rsp("sub_03_05", 8'hFE, 0, 1, 0, 0, 1);
    run_op(OP_SUB, 8'h05, 8'h05);
    check_rsp("sub_05_05", 8'h00, 1, 0, 0, 1, 0);
    run_op(OP_ADD, 8'hFF, 8'h01);
    check_rsp("add_carry_again", 8'h00, 1, 1, 0, 1, 1);
    run_op(OP_OR, 8'h12, 8'h40);
    check_rsp("or_12_40", 8'h52, 0, 0, 0, 0, 1);
    run_op(OP_BAD, 8'h55, 8'hAA);
    check_rsp("illegal", 8'h00, 1, 0, 1, 0, 1);
    run_op(OP_XOR, 8'h3C, 8'h0F);
    check_rsp("xor_3c_0f", 8'h33, 0, 0, 0, 0, 1);

    // Backpressure with a competing request pending on the requester side.
    bus.rsp_ready = 1'b0;
    run_op(OP_ADD, 8'h20, 8'h22);
    bus.req_valid = 1'b1;
    bus.req_mode  = OP_ADD;
    bus.req_a     = 8'h01;
    bus.req_b     = 8'h02;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_result", bus.rsp_result, 8'h42);
      chk("bp_req_ready", bus.req_ready, 0);
      chk("bp_alu_a_hold", bus.alu_a, 8'h20);
      chk("bp_enable", bus.alu_enable, 0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_release_idle", bus.req_ready, 1);
    chk("bp_release_no_accept", bus.alu_a, 8'h20);
    tick();
    chk("pending_accept_en", bus.alu_enable, 1);
    chk("pending_accept_a", bus.alu_a, 8'h01);
    bus.req_valid = 1'b0;
    tick();
    tick();
    chk("pending_k2_valid", bus.rsp_valid, 0);
    tick();
    chk("pending_k3_valid", bus.rsp_valid, 1);
    check_rsp("pending_add", 8'h03, 0, 0, 0, 0, 0);

    // Load flag_c so that a stray flag update from the aborted op would be visible.
    run_op(OP_ADD, 8'hFF, 8'h02);
    check_rsp("add_ff_02", 8'h01, 0, 1, 0, 0, 1);

    // Reset during WAIT aborts the op.
    bus.req_valid = 1'b1;
    bus.req_mode  = OP_ADD;
    bus.req_a     = 8'hFF;
    bus.req_b     = 8'h01;
    tick();
    bus.req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("abort_req_ready", bus.req_ready, 1);
    chk("abort_rsp_valid", bus.rsp_valid, 0);
    chk("abort_rsp", {bus.rsp_result, bus.rsp_zero, bus.rsp_carry, bus.rsp_err}, 0);
    chk("abort_flags", {bus.flag_z, bus.flag_c}, 0);
    chk("abort_alu_regs", {bus.alu_mode, bus.alu_a, bus.alu_b}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_rsp", bus.rsp_valid, 0);
      chk("abort_no_flag", {bus.flag_z, bus.flag_c}, 0);
    end

    run_op(OP_SUB, 8'h10, 8'h01);
    check_rsp("post_abort_sub", 8'h0F, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
